// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, sub-doubleword stores via aligned read-modify-write.
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module load_store_unit #(
   parameter int MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic [63:0] Mem_Addr,
   output logic [63:0] Write_Data,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [63:0] Read_Data,
   output logic [31:0] ld_count,
   output logic [31:0] st_count,
   output logic [31:0] err_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_ERR,
      S_RESP
   } state_t;

   localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rbuf_q, rbuf_d;

   logic        live;
   logic        req_misaligned;
   logic        req_oor;
   logic [5:0]  lane_bits;
   logic [63:0] base_addr;
   logic [63:0] size_mask;
   logic [63:0] merged;
   logic [63:0] shifted;
   logic [63:0] load_data;

   // Memory strobes and responses are suppressed combinationally while reset is high.
   assign live      = !reset;
   assign lane_bits = {addr_q[2:0], 3'b000};
   assign base_addr = {addr_q[63:3], 3'b000};

   always_comb begin
      req_misaligned = 1'b0;
      case (req_size)
         2'd0: req_misaligned = 1'b0;
         2'd1: req_misaligned = req_addr[0];
         2'd2: req_misaligned = |req_addr[1:0];
         default: req_misaligned = |req_addr[2:0];
      endcase
      req_oor = {req_addr[63:3], 3'b111} >= MEM_LIMIT;
   end

   always_comb begin
      size_mask = '1;
      case (size_q)
         2'd0: size_mask = 64'h0000_0000_0000_00FF;
         2'd1: size_mask = 64'h0000_0000_0000_FFFF;
         2'd2: size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = '1;
      endcase
      merged  = (rbuf_q & ~(size_mask << lane_bits)) | ((wdata_q & size_mask) << lane_bits);
      shifted = rbuf_q >> lane_bits;
      load_data = shifted;
      case (size_q)
         2'd0: load_data = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'd1: load_data = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'd2: load_data = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
      Mem_Addr   = '0;
      Write_Data = '0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_misaligned || req_oor)
                  state_d = S_ERR;
               else if (req_write && req_size == 2'd3)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end
         S_RD: begin
            MemRead  = live;
            Mem_Addr = live ? base_addr : '0;
            rbuf_d   = Read_Data;
            state_d  = write_q ? S_WR : S_RESP;
         end
         S_WR: begin
            MemWrite   = live;
            Mem_Addr   = live ? base_addr : '0;
            Write_Data = live ? merged : '0;
            state_d    = S_RESP;
         end
         S_ERR: begin
            rsp_valid = live;
            rsp_err   = live;
            state_d   = S_IDLE;
         end
         S_RESP: begin
            rsp_valid = live;
            rsp_rdata = (live && !write_q) ? load_data : '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         write_q <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
      end
   end

`ifdef LSU_PERF_CNT_EN
   logic [31:0] ld_count_q, ld_count_d;
   logic [31:0] st_count_q, st_count_d;
   logic [31:0] err_count_q, err_count_d;

   always_comb begin
      ld_count_d  = ld_count_q;
      st_count_d  = st_count_q;
      err_count_d = err_count_q;
      if (rsp_valid && rsp_err && err_count_q != '1)
         err_count_d = err_count_q + 32'd1;
      if (rsp_valid && !rsp_err && !write_q && ld_count_q != '1)
         ld_count_d = ld_count_q + 32'd1;
      if (rsp_valid && !rsp_err && write_q && st_count_q != '1)
         st_count_d = st_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ld_count_q  <= '0;
         st_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         ld_count_q  <= ld_count_d;
         st_count_q  <= st_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign ld_count  = ld_count_q;
   assign st_count  = st_count_q;
   assign err_count = err_count_q;
`else
   assign ld_count  = '0;
   assign st_count  = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, directed scenarios and randomized traffic.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic [63:0] Mem_Addr;
   logic [63:0] Write_Data;
   logic        MemWrite;
   logic        MemRead;
   logic [63:0] Read_Data;
   logic [31:0] ld_count, st_count, err_count;

   load_store_unit #(.MEM_BYTES(64)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
      .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data),
      .ld_count(ld_count), .st_count(st_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

`ifdef LSU_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   // Data_Memory stand-in: combinational read, write on the falling edge.
   logic [63:0] mem [8];
   assign Read_Data = mem[Mem_Addr[5:3]];
   always @(negedge clk) if (MemWrite) mem[Mem_Addr[5:3]] <= Write_Data;

   logic [7:0] ref_mem [64];
   int exp_ld = 0, exp_st = 0, exp_err = 0;
   int n_cmp = 0, n_fail = 0;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      int          lat;
      int          nrd;
      int          nwr;
      logic [63:0] wfull;
      logic [63:0] base;
   } exp_t;

   logic [63:0] o_rdata, o_rd_addr, o_wr_addr, o_wr_data;
   logic        o_err, o_got;
   int          o_lat, o_nrd, o_nwr, o_idle_bad, o_busy_rdy;

   function automatic exp_t predict(logic w, logic [1:0] sz, logic uns, logic [63:0] a, logic [63:0] wd);
      exp_t e;
      int n, b, ai;
      logic [63:0] val;
      n = 1 << sz;
      e.base = a - (a % 64'd8);
      e.err = (a % 64'(n) != 0) || (e.base + 64'd7 >= 64'd64);
      e.rdata = '0; e.wfull = '0; e.nrd = 0; e.nwr = 0; e.lat = 1;
      if (e.err) return e;
      b = int'(e.base);
      ai = int'(a);
      if (!w) begin
         val = '0;
         for (int i = 0; i < n; i++) val = val | (64'(ref_mem[ai + i]) << (8 * i));
         if (!uns && n < 8 && val[8 * n - 1]) val = val - (64'd1 << (8 * n));
         e.rdata = val; e.lat = 2; e.nrd = 1;
      end else begin
         e.lat = (n == 8) ? 2 : 3;
         e.nrd = (n == 8) ? 0 : 1;
         e.nwr = 1;
         for (int i = 0; i < 8; i++)
            e.wfull[8 * i +: 8] = (b + i >= ai && b + i < ai + n) ? wd[8 * (b + i - ai) +: 8] : ref_mem[b + i];
      end
      return e;
   endfunction

   task automatic commit(logic w, logic [1:0] sz, logic [63:0] a, logic [63:0] wd, exp_t e);
      if (e.err) exp_err++;
      else if (w) begin
         exp_st++;
         for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
      end else exp_ld++;
   endtask

   task automatic txn(logic w, logic [1:0] sz, logic uns, logic [63:0] a, logic [63:0] wd);
      int k;
      o_nrd = 0; o_nwr = 0; o_idle_bad = 0; o_busy_rdy = 0; o_got = 1'b0;
      o_rdata = 'x; o_err = 1'bx; o_lat = -1; o_rd_addr = 'x; o_wr_addr = 'x; o_wr_data = 'x;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      if (!req_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout req_ready=%0b required=1", req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (MemRead) begin o_nrd++; o_rd_addr = Mem_Addr; end
         if (MemWrite) begin o_nwr++; o_wr_addr = Mem_Addr; o_wr_data = Write_Data; end
         if (!MemRead && !MemWrite && (Mem_Addr != 0 || Write_Data != 0)) o_idle_bad++;
         if (req_ready) o_busy_rdy++;
         if (rsp_valid) begin o_got = 1'b1; o_lat = c; o_rdata = rsp_rdata; o_err = rsp_err; break; end
      end
      if (!o_got) begin
         n_cmp++; n_fail++;
         $display("FAIL rsp_timeout rsp_valid=0 required=1");
      end
   endtask

   task automatic issue(logic w, logic [1:0] sz, logic uns, logic [63:0] a, logic [63:0] wd, output exp_t e);
      e = predict(w, sz, uns, a, wd);
      txn(w, sz, uns, a, wd);
      commit(w, sz, a, wd, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_ld = 0; exp_st = 0; exp_err = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ((MemRead | MemWrite) !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ctl got=%0b%0b required=00", MemRead, MemWrite); end
      @(negedge clk);
      reset = 1'b0;
      exp_ld = 0; exp_st = 0; exp_err = 0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b required=1", req_ready); end
      n_cmp++; if ({rsp_valid, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp got=%0b%0b required=00", rsp_valid, rsp_err); end
      n_cmp++; if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL rst_rdata got=%h required=0", rsp_rdata); end
      n_cmp++; if ({ld_count, st_count, err_count} !== 96'd0) begin n_fail++; $display("FAIL rst_counters got=%0d/%0d/%0d required=0/0/0", ld_count, st_count, err_count); end
   endtask

   task automatic test_load();
      exp_t e;
      issue(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, e);
      n_cmp++; if (o_rdata !== 64'd5) begin n_fail++; $display("FAIL ld8_data got=%h required=5", o_rdata); end
      n_cmp++; if (o_lat !== 2) begin n_fail++; $display("FAIL ld8_latency got=%0d required=2", o_lat); end
      n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL ld8_err got=%0b required=0", o_err); end
      n_cmp++; if (o_nrd !== 1 || o_rd_addr !== 64'd8) begin n_fail++; $display("FAIL ld8_memread got=%0d@%h required=1@8", o_nrd, o_rd_addr); end
   endtask

   task automatic test_store_merge();
      exp_t e;
      issue(1'b1, 2'd3, 1'b0, 64'd16, 64'h80, e);
      n_cmp++; if (o_lat !== 2 || o_nrd !== 0 || o_nwr !== 1) begin n_fail++; $display("FAIL sd16_seq got=lat%0d rd%0d wr%0d required=lat2 rd0 wr1", o_lat, o_nrd, o_nwr); end
      issue(1'b0, 2'd0, 1'b0, 64'd16, 64'd0, e);
      n_cmp++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb16 got=%h required=ffffffffffffff80", o_rdata); end
      issue(1'b0, 2'd0, 1'b1, 64'd16, 64'd0, e);
      n_cmp++; if (o_rdata !== 64'h80) begin n_fail++; $display("FAIL lbu16 got=%h required=80", o_rdata); end
      issue(1'b0, 2'd1, 1'b0, 64'd16, 64'd0, e);
      n_cmp++; if (o_rdata !== 64'h80) begin n_fail++; $display("FAIL lh16 got=%h required=80", o_rdata); end
      issue(1'b1, 2'd0, 1'b0, 64'd41, 64'hFFFF_FFFF_FFFF_FFAB, e);
      n_cmp++; if (o_wr_data !== 64'hAB08 || o_wr_addr !== 64'd40) begin n_fail++; $display("FAIL sb41_write got=%h@%h required=ab08@28", o_wr_data, o_wr_addr); end
      n_cmp++; if (o_lat !== 3 || o_nrd !== 1 || o_rdata !== 64'd0) begin n_fail++; $display("FAIL sb41_rsp got=lat%0d rd%0d data%h required=lat3 rd1 data0", o_lat, o_nrd, o_rdata); end
      issue(1'b0, 2'd3, 1'b0, 64'd40, 64'd0, e);
      n_cmp++; if (o_rdata !== 64'hAB08) begin n_fail++; $display("FAIL ld40 got=%h required=ab08", o_rdata); end
   endtask

   task automatic test_errors();
      exp_t e;
      issue(1'b0, 2'd2, 1'b0, 64'd6, 64'd0, e);
      n_cmp++; if (o_err !== 1'b1 || o_lat !== 1 || o_rdata !== 64'd0) begin n_fail++; $display("FAIL lw6_err got=err%0b lat%0d data%h required=err1 lat1 data0", o_err, o_lat, o_rdata); end
      n_cmp++; if (o_nrd + o_nwr !== 0) begin n_fail++; $display("FAIL lw6_mem got=%0d accesses required=0", o_nrd + o_nwr); end
      issue(1'b1, 2'd3, 1'b0, 64'd64, 64'h1234, e);
      n_cmp++; if (o_err !== 1'b1 || o_lat !== 1) begin n_fail++; $display("FAIL sd64_err got=err%0b lat%0d required=err1 lat1", o_err, o_lat); end
      n_cmp++; if (o_nrd + o_nwr !== 0) begin n_fail++; $display("FAIL sd64_mem got=%0d accesses required=0", o_nrd + o_nwr); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = 64'd26; req_wdata = 64'h1234;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%0b required=1", req_ready); end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (MemRead !== 1'b1) begin n_fail++; $display("FAIL mid_rd got=%0b required=1", MemRead); end
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL mid_wr_gated got=%0b required=0", MemWrite); end
      @(posedge clk);
      #1 reset = 1'b0;
      exp_ld = 0; exp_st = 0; exp_err = 0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after got=rdy%0b rsp%0b required=rdy1 rsp0", req_ready, rsp_valid); end
      issue(1'b0, 2'd3, 1'b0, 64'd24, 64'd0, e);
      n_cmp++; if (o_rdata !== 64'd3 || o_rdata !== e.rdata) begin n_fail++; $display("FAIL mid_ld24 got=%h required=3", o_rdata); end
   endtask

   task automatic test_back_to_back();
      exp_t e0, e1;
      int cyc, acc_n, rsp_n;
      int acc_cyc [2];
      int rsp_cyc [2];
      logic [63:0] rsp_dat [2];
      do_reset();
      e0 = predict(1'b0, 2'd3, 1'b0, 64'd0, 64'd0);
      e1 = predict(1'b0, 2'd3, 1'b0, 64'd32, 64'd0);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'd0;
      cyc = 0; acc_n = 0; rsp_n = 0;
      while (cyc < 20 && rsp_n < 2) begin
         if (rsp_valid) begin rsp_cyc[rsp_n] = cyc; rsp_dat[rsp_n] = rsp_rdata; rsp_n++; end
         if (req_ready && req_valid && acc_n < 2) begin
            acc_cyc[acc_n] = cyc; acc_n++;
            @(posedge clk);
            #1;
            if (acc_n == 1) req_addr = 64'd32; else req_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      if (acc_n < 2 || rsp_n < 2) begin
         n_cmp++; n_fail++;
         $display("FAIL b2b_timeout got=acc%0d rsp%0d required=acc2 rsp2", acc_n, rsp_n);
      end else begin
         commit(1'b0, 2'd3, 64'd0, 64'd0, e0);
         commit(1'b0, 2'd3, 64'd32, 64'd0, e1);
         n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin n_fail++; $display("FAIL b2b_spacing got=%0d required=3", acc_cyc[1] - acc_cyc[0]); end
         n_cmp++; if (rsp_cyc[0] - acc_cyc[0] !== 2) begin n_fail++; $display("FAIL b2b_latency got=%0d required=2", rsp_cyc[0] - acc_cyc[0]); end
         n_cmp++; if (rsp_dat[0] !== 64'd2 || rsp_dat[0] !== e0.rdata) begin n_fail++; $display("FAIL b2b_data0 got=%h required=2", rsp_dat[0]); end
         n_cmp++; if (rsp_dat[1] !== 64'd4 || rsp_dat[1] !== e1.rdata) begin n_fail++; $display("FAIL b2b_data1 got=%h required=4", rsp_dat[1]); end
         @(negedge clk);
         n_cmp++; if (ld_count !== (CNT_EN ? 32'(exp_ld) : 32'd0)) begin n_fail++; $display("FAIL b2b_ld_count got=%0d required=%0d", ld_count, CNT_EN ? exp_ld : 0); end
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic w, uns;
      logic [1:0] sz;
      logic [63:0] a, wd;
      for (int t = 0; t < 80; t++) begin
         w = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         wd = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
         else a = 64'($urandom_range(0, 71));
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         issue(w, sz, uns, a, wd, e);
         n_cmp++; if (o_err !== e.err) begin n_fail++; $display("FAIL rnd%0d_err got=%0b required=%0b addr=%h", t, o_err, e.err, a); end
         n_cmp++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got=%h required=%h", t, o_rdata, e.rdata); end
         n_cmp++; if (o_lat !== e.lat) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d required=%0d", t, o_lat, e.lat); end
         n_cmp++; if (o_nrd !== e.nrd || o_nwr !== e.nwr) begin n_fail++; $display("FAIL rnd%0d_accesses got=rd%0d wr%0d required=rd%0d wr%0d", t, o_nrd, o_nwr, e.nrd, e.nwr); end
         n_cmp++; if (o_idle_bad !== 0 || o_busy_rdy !== 0) begin n_fail++; $display("FAIL rnd%0d_idle got=bus%0d rdy%0d required=0/0", t, o_idle_bad, o_busy_rdy); end
         if (e.nwr == 1) begin
            n_cmp++; if (o_wr_data !== e.wfull || o_wr_addr !== e.base) begin n_fail++; $display("FAIL rnd%0d_write got=%h@%h required=%h@%h", t, o_wr_data, o_wr_addr, e.wfull, e.base); end
         end
         if (e.nrd == 1) begin
            n_cmp++; if (o_rd_addr !== e.base) begin n_fail++; $display("FAIL rnd%0d_rdaddr got=%h required=%h", t, o_rd_addr, e.base); end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (ld_count !== (CNT_EN ? 32'(exp_ld) : 32'd0) || st_count !== (CNT_EN ? 32'(exp_st) : 32'd0)
          || err_count !== (CNT_EN ? 32'(exp_err) : 32'd0)) begin
         n_fail++;
         $display("FAIL rnd_counters got=%0d/%0d/%0d model=%0d/%0d/%0d enabled=%0b", ld_count, st_count, err_count, exp_ld, exp_st, exp_err, CNT_EN);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      mem[0] = 64'd2; mem[1] = 64'd5; mem[2] = 64'd6; mem[3] = 64'd3; mem[4] = 64'd4; mem[5] = 64'd8;
      for (int i = 0; i < 64; i++) ref_mem[i] = mem[i / 8][8 * (i % 8) +: 8];
      test_reset();
      test_load();
      test_store_merge();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
